// File: rtl/dds_pkg.sv
// Shared definitions for the DDS parameter ramp block: default widths,
// the ramp controller state encoding and reset values.
package dds_pkg;

  // Default datapath widths.
  localparam int PINC_W_DEF = 32;
  localparam int AMPL_W_DEF = 12;
  localparam int DIV_W_DEF  = 16;

  // Ramp controller states: IDLE holds outputs, RAMP slews toward targets.
  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  // Reset values of the controller.
  localparam ramp_state_e RST_STATE = IDLE;
  localparam logic        RST_BUSY  = 1'b0;
  localparam logic        RST_DONE  = 1'b0;

endpackage

// File: rtl/ramp_axis.sv
// Single-axis clamp-stepper. Holds the current value plus the captured
// target and step. On step_en the value moves one step toward the target,
// landing exactly on it when the remaining distance is no larger than the
// step (or the step is zero). The value never overshoots and never wraps.
// at_target reports whether the value produced by this step equals target.
module ramp_axis #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step_en,
  input  logic [W-1:0] target_in,
  input  logic [W-1:0] step_in,
  output logic [W-1:0] value,
  output logic         at_target
);

  logic [W-1:0]        cur_q;
  logic [W-1:0]        tgt_q;
  logic [W-1:0]        step_q;
  logic [W-1:0]        next_d;
  logic signed [W:0]   diff_s;
  logic [W:0]          mag;
  logic                close_enough;

  // Signed distance to target at W+1 bits, its magnitude, and the clamped next value.
  always_comb begin
    diff_s       = signed'({1'b0, tgt_q}) - signed'({1'b0, cur_q});
    mag          = diff_s[W] ? unsigned'(-diff_s) : unsigned'(diff_s);
    close_enough = (step_q == '0) || (mag <= {1'b0, step_q});
    next_d       = cur_q;
    if (close_enough) begin
      next_d = tgt_q;
    end else if (diff_s[W]) begin
      // |diff| > step, so subtracting cannot pass below the target.
      next_d = cur_q - step_q;
    end else begin
      // |diff| > step, so adding cannot pass above the target.
      next_d = cur_q + step_q;
    end
  end

  // Capture target/step on load; advance the current value on step events.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= '0;
      tgt_q  <= '0;
      step_q <= '0;
    end else if (load) begin
      // Retarget from wherever the output currently is; no jump.
      tgt_q  <= target_in;
      step_q <= step_in;
    end else if (step_en) begin
      cur_q  <= next_d;
    end
  end

  assign value     = cur_q;
  assign at_target = (next_d == tgt_q);

endmodule

// File: rtl/dds_param_ramp.sv
// DDS parameter ramp. Slews the phase increment (and, when the macro
// DDS_AMPL_RAMP_EN is defined, the amplitude) toward loaded targets in
// fixed steps paced by the DAC sample tick. Without DDS_AMPL_RAMP_EN the
// amplitude follows its target on the cycle after load and only the
// phase-increment axis governs busy/done.
//
// Handshake: load is a one-cycle strobe and always wins over a coincident
// sample_tick (that tick is dropped). busy is high from the cycle after load
// until the edge on which both axes land on target; done pulses for exactly
// that one cycle. There is no back-pressure.
//
// dbg_state / dbg_div_cnt expose the controller state and divider count.
module dds_param_ramp
  import dds_pkg::*;
#(
  parameter int PINC_W = PINC_W_DEF,
  parameter int AMPL_W = AMPL_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk_fpga,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              load,
  input  logic [PINC_W-1:0] pinc_target,
  input  logic [AMPL_W-1:0] ampl_target,
  input  logic [PINC_W-1:0] pinc_step,
  input  logic [AMPL_W-1:0] ampl_step,
  input  logic [DIV_W-1:0]  step_div,
  output logic [PINC_W-1:0] pinc,
  output logic [AMPL_W-1:0] ampl,
  output logic              busy,
  output logic              done,
  output logic              dbg_state,
  output logic [DIV_W-1:0]  dbg_div_cnt
);

  ramp_state_e      state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] step_div_q;
  logic             busy_q;
  logic             done_q;

  logic             tick_ok;
  logic             step_evt;
  logic             pinc_at;
  logic             ampl_at;
  logic             all_at;

  // A tick counts only in RAMP and only when no load is competing with it.
  always_comb begin
    tick_ok  = (state_q == RAMP) && sample_tick && !load;
    step_evt = tick_ok && (div_cnt_q == step_div_q);
    all_at   = pinc_at && ampl_at;
  end

  ramp_axis #(.W(PINC_W)) u_pinc_axis (
    .clk       (clk_fpga),
    .rst       (rst),
    .load      (load),
    .step_en   (step_evt),
    .target_in (pinc_target),
    .step_in   (pinc_step),
    .value     (pinc),
    .at_target (pinc_at)
  );

`ifdef DDS_AMPL_RAMP_EN
  ramp_axis #(.W(AMPL_W)) u_ampl_axis (
    .clk       (clk_fpga),
    .rst       (rst),
    .load      (load),
    .step_en   (step_evt),
    .target_in (ampl_target),
    .step_in   (ampl_step),
    .value     (ampl),
    .at_target (ampl_at)
  );
`else
  logic [AMPL_W-1:0] ampl_q;
  logic              ampl_step_unused;

  // Amplitude jumps straight to its target the cycle after load.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      ampl_q <= '0;
    end else if (load) begin
      ampl_q <= ampl_target;
    end
  end

  assign ampl             = ampl_q;
  assign ampl_at          = 1'b1;
  // The amplitude step has no effect when the amplitude axis is absent.
  assign ampl_step_unused = ^ampl_step;
`endif

  // Controller FSM: divider pacing, busy/done generation, retarget handling.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q    <= RST_STATE;
      div_cnt_q  <= '0;
      step_div_q <= '0;
      busy_q     <= RST_BUSY;
      done_q     <= RST_DONE;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        step_div_q <= step_div;
        div_cnt_q  <= '0;
        state_q    <= RAMP;
        busy_q     <= 1'b1;
      end else if (tick_ok) begin
        if (div_cnt_q == step_div_q) begin
          div_cnt_q <= '0;
          if (all_at) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;
  assign dbg_div_cnt = div_cnt_q;

endmodule

// File: tb/tb_dds_param_ramp.sv
// Bench for dds_param_ramp: directed loads/ticks with hand-computed output
// updates pushed to an expected queue; a negedge monitor pops one entry
// whenever pinc/ampl change or done pulses. Each entry also carries the tick
// number after which the update must appear, so update pacing is checked.
module tb_dds_param_ramp;
  import dds_pkg::*;

  localparam int PW = 32;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RW = 16 + PW + AW + 2;

  logic          clk_fpga = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] pinc_target = '0;
  logic [AW-1:0] ampl_target = '0;
  logic [PW-1:0] pinc_step = '0;
  logic [AW-1:0] ampl_step = '0;
  logic [DW-1:0] step_div = '0;
  logic [PW-1:0] pinc;
  logic [AW-1:0] ampl;
  logic          busy;
  logic          done;
  logic          dbg_state;
  logic [DW-1:0] dbg_div_cnt;

  dds_param_ramp #(.PINC_W(PW), .AMPL_W(AW), .DIV_W(DW)) dut (
    .clk_fpga    (clk_fpga),
    .rst         (rst),
    .sample_tick (sample_tick),
    .load        (load),
    .pinc_target (pinc_target),
    .ampl_target (ampl_target),
    .pinc_step   (pinc_step),
    .ampl_step   (ampl_step),
    .step_div    (step_div),
    .pinc        (pinc),
    .ampl        (ampl),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state),
    .dbg_div_cnt (dbg_div_cnt)
  );

  // Clock and scoreboard state
  always #5 clk_fpga = ~clk_fpga;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [15:0]   tick_no = '0;
  logic          mon_en = 1'b0;
  logic [RW-1:0] exp_q[$];
  logic [PW-1:0] prev_pinc;
  logic [AW-1:0] prev_ampl;

  function automatic logic [RW-1:0] rec(input logic [15:0] t, input logic [PW-1:0] p,
                                         input logic [AW-1:0] a, input logic d, input logic b);
    return {t, p, a, d, b};
  endfunction

  // Monitor: every output update or done pulse consumes one expected entry.
  always @(negedge clk_fpga) begin
    logic [RW-1:0] act_r;
    logic [RW-1:0] exp_r;
    if (mon_en && (pinc !== prev_pinc || ampl !== prev_ampl || done === 1'b1)) begin
      act_r = rec(tick_no, pinc, ampl, done, busy);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_update: got tick=%0d pinc=%h ampl=%h done=%b busy=%b, expected no update",
                 tick_no, pinc, ampl, done, busy);
      end else begin
        exp_r = exp_q.pop_front();
        if (act_r !== exp_r) begin
          n_fail++;
          $display("FAIL update: got tick=%0d pinc=%h ampl=%h done=%b busy=%b, expected tick=%0d pinc=%h ampl=%h done=%b busy=%b",
                   tick_no, pinc, ampl, done, busy,
                   exp_r[RW-1 -: 16], exp_r[PW+AW+1 -: PW], exp_r[AW+1 -: AW], exp_r[1], exp_r[0]);
        end
      end
    end
    prev_pinc = pinc;
    prev_ampl = ampl;
  end

  // Driver tasks: all inputs change 1 time unit after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_fpga);
    #1;
  endtask

  task automatic do_load(input logic [PW-1:0] pt, input logic [AW-1:0] at,
                         input logic [PW-1:0] ps, input logic [AW-1:0] as, input logic [DW-1:0] dv);
    pinc_target = pt;
    ampl_target = at;
    pinc_step   = ps;
    ampl_step   = as;
    step_div    = dv;
    load        = 1'b1;
    wait_cyc(1);
    load        = 1'b0;
  endtask

  task automatic tick(input int gap);
    if (gap > 0) wait_cyc(gap);
    sample_tick = 1'b1;
    tick_no     = tick_no + 16'd1;
    wait_cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Directed stimulus
  initial begin
    wait_cyc(3);
    rst = 1'b0;
    check("rst_pinc", 64'(pinc), 64'd0);
    check("rst_ampl", 64'(ampl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_div_cnt", 64'(dbg_div_cnt), 64'd0);
    mon_en = 1'b1;

    // Rising ramp, one step per tick, ticks every 36 cycles.
    do_load(32'd1000, 12'h000, 32'd300, 12'h000, 16'd0);
    check("busy_after_load", 64'(busy), 64'd1);
    check("pinc_hold_on_load", 64'(pinc), 64'd0);
    exp_q.push_back(rec(16'd1, 32'd300,  12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd2, 32'd600,  12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd3, 32'd900,  12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd4, 32'd1000, 12'h000, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) tick(35);
    wait_cyc(4);
    check("busy_after_done", 64'(busy), 64'd0);
    check("state_after_done", 64'(dbg_state), 64'(IDLE));
    tick(2);  // tick 5: ignored in IDLE
    check("idle_tick_div_cnt", 64'(dbg_div_cnt), 64'd0);

    // Falling ramp with step_div=2; clamps at 0 without underflow.
    do_load(32'd0, 12'h000, 32'd400, 12'h000, 16'd2);
    exp_q.push_back(rec(16'd8,  32'd600, 12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd11, 32'd200, 12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd14, 32'd0,   12'h000, 1'b1, 1'b0));
    for (int i = 0; i < 9; i++) tick(2);

    // Step 0 jumps; then a step near the top of range must not wrap.
    do_load(32'hFFFF_FF00, 12'h000, 32'd0, 12'h000, 16'd0);
    exp_q.push_back(rec(16'd15, 32'hFFFF_FF00, 12'h000, 1'b1, 1'b0));
    tick(2);
    do_load(32'hFFFF_FFF0, 12'h000, 32'h100, 12'h000, 16'd0);
    exp_q.push_back(rec(16'd16, 32'hFFFF_FFF0, 12'h000, 1'b1, 1'b0));
    tick(2);

    // Retarget mid-ramp: 0 -> 300 -> 600, reload 100 -> 300 -> 100.
    do_load(32'd0, 12'h000, 32'd0, 12'h000, 16'd0);
    exp_q.push_back(rec(16'd17, 32'd0, 12'h000, 1'b1, 1'b0));
    tick(2);
    do_load(32'd1000, 12'h000, 32'd300, 12'h000, 16'd0);
    exp_q.push_back(rec(16'd18, 32'd300, 12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd19, 32'd600, 12'h000, 1'b0, 1'b1));
    tick(2);
    tick(2);
    do_load(32'd100, 12'h000, 32'd300, 12'h000, 16'd0);
    check("busy_on_retarget", 64'(busy), 64'd1);
    exp_q.push_back(rec(16'd20, 32'd300, 12'h000, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd21, 32'd100, 12'h000, 1'b1, 1'b0));
    tick(2);
    check("busy_mid_retarget", 64'(busy), 64'd1);
    tick(2);

    // load + tick together: load wins, divider cleared, no output change.
    do_load(32'd1000, 12'h000, 32'd300, 12'h000, 16'd1);
    tick(2);  // tick 22: div_cnt 0 -> 1
    check("div_cnt_counting", 64'(dbg_div_cnt), 64'd1);
    wait_cyc(2);
    load        = 1'b1;
    sample_tick = 1'b1;
    tick_no     = tick_no + 16'd1;  // tick 23 is discarded
    wait_cyc(1);
    load        = 1'b0;
    sample_tick = 1'b0;
    check("coinc_pinc_hold", 64'(pinc), 64'd100);
    check("coinc_div_cnt", 64'(dbg_div_cnt), 64'd0);
    exp_q.push_back(rec(16'd25, 32'd400, 12'h000, 1'b0, 1'b1));
    tick(2);
    tick(2);

    // Reset mid-ramp: outputs to 0 on the next edge, no done afterwards.
    wait_cyc(2);
    exp_q.push_back(rec(16'd25, 32'd0, 12'h000, 1'b0, 1'b0));
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("midrst_pinc", 64'(pinc), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    wait_cyc(10);

    // Amplitude behaviour.
`ifdef DDS_AMPL_RAMP_EN
    do_load(32'd0, 12'h800, 32'd0, 12'h200, 16'd0);
    exp_q.push_back(rec(16'd26, 32'd0, 12'h200, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd27, 32'd0, 12'h400, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd28, 32'd0, 12'h600, 1'b0, 1'b1));
    exp_q.push_back(rec(16'd29, 32'd0, 12'h800, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) tick(2);
`else
    exp_q.push_back(rec(16'd25, 32'd0, 12'h800, 1'b0, 1'b1));
    do_load(32'd0, 12'h800, 32'd0, 12'h123, 16'd0);
    wait_cyc(20);
    check("ampl_no_tick", 64'(ampl), 64'h800);
    exp_q.push_back(rec(16'd26, 32'd0, 12'h800, 1'b1, 1'b0));
    tick(2);
`endif

    // Drain: every expected update must have been observed.
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk_fpga);
    wait_cyc(5);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending updates, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_param_ramp.md
# dds_param_ramp

Slews the DDS phase increment and amplitude from their current values toward newly loaded targets in fixed steps, instead of jumping. Sits between the SPI command decoder, which supplies targets and a load strobe, and the DAC8830 DDS/driver, which consumes `pinc`/`ampl`. Steps are paced by the DAC sample tick, so sweep rate is independent of the fabric clock.

## Interface
Parameters:
- `PINC_W`, 32, phase-increment width
- `AMPL_W`, 12, amplitude width
- `DIV_W`, 16, width of the step-interval divider

Ports:
- `clk_fpga`  in  1  fabric clock (72 MHz)
- `rst`  in  1  synchronous, active-high reset
- `sample_tick`  in  1  one-cycle pulse per DAC sample, already in `clk_fpga` domain
- `load`  in  1  one-cycle strobe: capture targets/steps
- `pinc_target`  in  PINC_W  desired phase increment
- `ampl_target`  in  AMPL_W  desired amplitude
- `pinc_step`  in  PINC_W  unsigned step magnitude per interval
- `ampl_step`  in  AMPL_W  unsigned step magnitude per interval
- `step_div`  in  DIV_W  sample ticks per step, minus 1
- `pinc`  out  PINC_W  current phase increment to DDS
- `ampl`  out  AMPL_W  current amplitude to DDS
- `busy`  out  1  high while either axis is off target
- `done`  out  1  one-cycle pulse when both axes reach target

## Operation
- States: `IDLE`, `RAMP`.
- On `load`, capture all five inputs, clear divider count, and enter `RAMP`. Outputs are not changed that cycle.
- `load` in `RAMP` retargets from the current outputs, with no jump. `load` with targets equal to outputs enters `RAMP` and leaves on the next step event with `done`.
- Step event: a `sample_tick` while `div_cnt == step_div` in `RAMP`. `div_cnt` then clears; any other tick increments it.
- Per axis, on a step event:
  - diff = target − current, computed at width+1 bits, signed.
  - If |diff| ≤ step, or step == 0, the axis becomes target.
  - Otherwise current ± step toward target.
  - The result never overshoots and never wraps.
- Step of 0 on an axis means an immediate jump on the first step event.
- When both axes equal target after a step event, go to `IDLE`, pulse `done` for 1 cycle, and drop `busy`.
- `sample_tick` in `IDLE` is ignored.
- `load` and `sample_tick` in the same cycle: load wins and the tick is discarded.

## Timing
- Reset values: `pinc`=0, `ampl`=0, `busy`=0, `done`=0, state `IDLE`, `div_cnt`=0, captured registers 0.
- `rst` mid-ramp aborts immediately. Outputs return to 0 on the next edge, with no `done`.
- `busy` rises the cycle after `load`.
- Outputs update the cycle after a qualifying tick (1-cycle registered latency).
- `done` and the final output value appear on the same edge; `busy` falls on that same edge.
- Ramp length = ceil(|Δ|/step) step events = that count × (step_div+1) sample ticks.

## Configuration
- `DDS_AMPL_RAMP_EN` defined: amplitude ramps exactly as above.
- `DDS_AMPL_RAMP_EN` undefined:
  - `ampl` takes `ampl_target` on the cycle after `load`.
  - `ampl_step` is ignored and only `pinc` governs `busy`/`done`.
  - The amplitude axis logic is not instantiated.

## Structure
- Shared package `dds_pkg`: `PINC_W`/`AMPL_W` defaults, the `IDLE`/`RAMP` state enum, and reset constants.
- One natural sub-module, `ramp_axis`: a parameterised single-axis clamp-stepper (current, target, step, `step_en`, `load` → next value and `at_target`). Instantiated once for `pinc` and, under the macro, once for `ampl`.

## Test plan
- Reset, then load `pinc_target`=1000, `pinc_step`=300, `step_div`=0, ticks every 36 cycles → `pinc` steps 300, 600, 900, 1000; `done` pulses once with the 1000 update.
- From `pinc`=1000, load target 0, step 400, `step_div`=2 → values 600, 200, 0, changing only every 3rd tick; no underflow past 0.
- Load target 0xFFFF_FFF0 from 0xFFFF_FF00 with step 0x100 → single step to 0xFFFF_FFF0, with no wrap to small values.
- Mid-ramp (`pinc`=600 rising to 1000), load target 100 → next step gives 300, then 100; `busy` stays high throughout and there is exactly one `done`.
- Assert `load` and `sample_tick` in the same cycle → no output change on the next edge; `div_cnt` is 0. Assert `rst` mid-ramp → all outputs 0 and no `done`.
- With `DDS_AMPL_RAMP_EN` undefined, load `ampl_target`=0x800 → `ampl`=0x800 on the next cycle regardless of ticks. With it defined, step 0x200 → 0x200, 0x400, 0x600, 0x800.
